// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and width helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    localparam int NREQ_DEF     = 4;
    localparam int DSIZE_DEF    = 8;
    localparam int MAXBURST_DEF = 4;

    function automatic int ptr_w(input int nreq);
        return nreq > 1 ? $clog2(nreq) : 1;
    endfunction

    function automatic int cnt_w(input int maxburst);
        return $clog2(maxburst) + 1;
    endfunction

    localparam int PTR_W_DEF = ptr_w(NREQ_DEF);
    localparam int CNT_W_DEF = cnt_w(MAXBURST_DEF);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: first set request at or after start, wrapping (rotate, priority-encode, rotate back)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [ptr_w(NREQ)-1:0] start,
    output logic [NREQ-1:0]        pick,
    output logic [ptr_w(NREQ)-1:0] idx,
    output logic                   any
);

    localparam int PW = ptr_w(NREQ);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                off;
    int                sum;

    always_comb begin
        dbl = {req, req} >> start;
        rot = dbl[NREQ-1:0];
        off = 0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) off = i;
        sum = off + int'(start);
        sum = sum >= NREQ ? sum - NREQ : sum;
        idx = PW'(sum);
        any = |req;
        pick = '0;
        pick[idx] = any;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of the FIFO write port with bounded contiguous bursts
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic [NREQ-1:0]         grant,
    output logic                    busy
);

    localparam int PW = ptr_w(NREQ);
    localparam int CW = cnt_w(MAXBURST);

    state_t          state, state_nxt;
    logic [NREQ-1:0] pick;
    logic [PW-1:0]   pick_idx, owner, rr_ptr, owner_nxt;
    logic            any, beat, end_burst;
    logic [CW-1:0]   beat_cnt;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .start (rr_ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .any   (any)
    );

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) state <= IDLE;
        else      state <= state_nxt;
    end

    // A valid drop and the final counted beat in one cycle still yield a single end
    always_comb begin
        beat      = state == BURST && req_valid[owner] && !wfull;
        end_burst = state == BURST && (!req_valid[owner] || (beat && beat_cnt == CW'(MAXBURST - 1)));
        owner_nxt = owner == PW'(NREQ - 1) ? '0 : owner + 1'b1;
        state_nxt = state == IDLE ? (any ? BURST : IDLE) : (end_burst ? IDLE : BURST);
    end

    always_comb begin
        busy      = state == BURST;
        winc      = beat;
        req_ready = busy && !wfull ? grant : '0;
        wdata     = busy ? req_data[owner*DSIZE +: DSIZE] : '0;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE && any) begin
            grant    <= pick;
            owner    <= pick_idx;
            beat_cnt <= '0;
        end else if (end_burst) begin
            grant  <= '0;
            rr_ptr <= owner_nxt;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench; expected FIFO beats queued as sources are loaded
module tb_fifo_wr_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
    } beat_t;

    logic        wclk = 0;
    logic        wrst = 1;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        wfull = 0;
    logic        winc;
    logic [7:0]  wdata;
    logic [3:0]  grant;
    logic        busy;

    beat_t      sb[$];
    logic [7:0] data[4];
    int         rem[4];
    logic [3:0] fire;
    logic [3:0] obs_grant, obs_ready;
    logic       obs_winc, obs_busy;
    int         n_cmp = 0;
    int         n_bad = 0;

    fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAXBURST(4)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    assert property (@(posedge wclk) !(winc && wfull));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        beat_t e;
        e.g = 4'b0001 << i;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]         = rem[i] != 0;
            req_data[i*8 +: 8]   = data[i];
        end
    endtask

    // Observe at negedge, let the FIFO capture at posedge, then advance sources
    task automatic cycle();
        beat_t e;
        @(negedge wclk);
        obs_grant = grant;
        obs_ready = req_ready;
        obs_winc  = winc;
        obs_busy  = busy;
        chk("winc_vs_wfull", {31'b0, winc & wfull}, 0);
        if (winc) begin
            if (sb.size() == 0) begin
                chk("extra_beat", {24'b0, wdata}, 32'hffff_ffff);
            end else begin
                e = sb.pop_front();
                chk("wdata", {24'b0, wdata}, {24'b0, e.d});
                chk("beat_grant", {28'b0, grant}, {28'b0, e.g});
            end
        end
        fire = req_ready & req_valid;
        @(posedge wclk);
        #1;
        for (int i = 0; i < 4; i++)
            if (fire[i]) begin
                data[i]++;
                rem[i]--;
            end
        drive();
    endtask

    task automatic do_reset();
        wrst = 1;
        @(posedge wclk);
        #1;
        wrst = 0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rem[i]  = 0;
            data[i] = '0;
        end
        drive();
        repeat (2) @(posedge wclk);
        #1;
        chk("rst_grant", {28'b0, grant}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        wrst = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("idle_grant", {28'b0, obs_grant}, 0);
            chk("idle_winc", {31'b0, obs_winc}, 0);
            chk("idle_ready", {28'b0, obs_ready}, 0);
            chk("idle_busy", {31'b0, obs_busy}, 0);
        end

        // single requester, two back-to-back bursts
        data[1] = 8'h10;
        rem[1]  = 8;
        for (int k = 0; k < 8; k++) push(1, 8'h10 + 8'(k));
        drive();
        cycle();
        chk("t2_arb_cycle", {28'b0, obs_grant}, 0);
        cycle();
        chk("t2_grant", {28'b0, obs_grant}, 4'b0010);
        chk("t2_busy", {31'b0, obs_busy}, 1);
        repeat (3) cycle();
        cycle();
        chk("t2_gap", {28'b0, obs_grant}, 0);
        chk("t2_rr_ptr", {30'b0, dut.rr_ptr}, 2);
        cycle();
        chk("t2_regrant", {28'b0, obs_grant}, 4'b0010);
        repeat (6) cycle();
        chk("t2_drain", sb.size(), 0);

        // round robin over all four
        do_reset();
        for (int i = 0; i < 4; i++) begin
            data[i] = 8'(i * 32);
            rem[i]  = 8;
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) push(i, 8'(i * 32 + r * 4 + k));
        drive();
        cycle();
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 4; k++) begin
                cycle();
                chk("t3_owner", {28'b0, obs_grant}, 32'(1 << (b % 4)));
                chk("t3_winc", {31'b0, obs_winc}, 1);
            end
            cycle();
            chk("t3_gap", {28'b0, obs_grant}, 0);
        end
        chk("t3_drain", sb.size(), 0);

        // back-pressure during burst cycles 2-5
        data[0] = 8'h80;
        rem[0]  = 4;
        for (int k = 0; k < 4; k++) push(0, 8'h80 + 8'(k));
        drive();
        cycle();
        cycle();
        chk("t4_first_beat", {31'b0, obs_winc}, 1);
        wfull = 1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t4_stall_winc", {31'b0, obs_winc}, 0);
            chk("t4_stall_ready", {28'b0, obs_ready}, 0);
            chk("t4_stall_grant", {28'b0, obs_grant}, 4'b0001);
            chk("t4_beat_cnt", {29'b0, dut.beat_cnt}, 1);
        end
        wfull = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t4_resume", {31'b0, obs_winc}, 1);
        end
        cycle();
        chk("t4_end", {28'b0, obs_grant}, 0);
        chk("t4_drain", sb.size(), 0);

        // requester 2 drops valid after two beats
        data[2] = 8'hA0;
        rem[2]  = 2;
        data[0] = 8'hC0;
        rem[0]  = 4;
        push(2, 8'hA0);
        push(2, 8'hA1);
        for (int k = 0; k < 4; k++) push(0, 8'hC0 + 8'(k));
        drive();
        cycle();
        cycle();
        chk("t5_grant", {28'b0, obs_grant}, 4'b0100);
        cycle();
        cycle();
        chk("t5_drop_grant", {28'b0, obs_grant}, 4'b0100);
        chk("t5_drop_winc", {31'b0, obs_winc}, 0);
        cycle();
        chk("t5_gap", {28'b0, obs_grant}, 0);
        chk("t5_rr_ptr", {30'b0, dut.rr_ptr}, 3);
        cycle();
        chk("t5_next", {28'b0, obs_grant}, 4'b0001);
        repeat (5) cycle();
        chk("t5_drain", sb.size(), 0);

        // asynchronous reset mid-burst
        data[3] = 8'hE0;
        rem[3]  = 8;
        data[0] = 8'h50;
        rem[0]  = 4;
        push(3, 8'hE0);
        push(3, 8'hE1);
        drive();
        cycle();
        cycle();
        chk("t6_grant", {28'b0, obs_grant}, 4'b1000);
        cycle();
        wrst = 1;
        #1;
        chk("t6_rst_grant", {28'b0, grant}, 0);
        chk("t6_rst_winc", {31'b0, winc}, 0);
        chk("t6_rst_busy", {31'b0, busy}, 0);
        chk("t6_rst_ptr", {30'b0, dut.rr_ptr}, 0);
        for (int k = 0; k < 4; k++) push(0, 8'h50 + 8'(k));
        for (int k = 2; k < 8; k++) push(3, 8'hE0 + 8'(k));
        cycle();
        wrst = 0;
        cycle();
        chk("t6_arb_cycle", {28'b0, obs_grant}, 0);
        cycle();
        chk("t6_restart", {28'b0, obs_grant}, 4'b0001);
        repeat (20) cycle();
        chk("t6_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO, in the write clock domain. It shares the single FIFO write port (winc/wdata, back-pressured by wfull) among NREQ requesters. Each requester sees a valid/ready handshake. A granted requester holds the port for a bounded burst, which keeps each requester's beats contiguous in the FIFO.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DSIZE, 8, data width, matches FIFO data width
- MAXBURST, 4, maximum beats per grant (1..16)

Ports:
- wclk  in  1  write-domain clock
- wrst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester data valid
- req_data  in  NREQ*DSIZE  requester i occupies bits [i*DSIZE +: DSIZE]
- req_ready  out  NREQ  per-requester beat accepted this cycle
- wfull  in  1  FIFO full flag (registered, write domain)
- winc  out  1  FIFO write enable
- wdata  out  DSIZE  FIFO write data
- grant  out  NREQ  one-hot current owner, all-zero when idle
- busy  out  1  high in BURST state

## Operation
- Two-state FSM: IDLE, BURST.
- IDLE:
  - If any req_valid is high, select the first valid index at or after rr_ptr, wrapping modulo NREQ.
  - Register grant to that index, clear beat_cnt, go to BURST.
  - No data moves in IDLE.
- BURST, owner g:
  - req_ready[g] = ~wfull. All other req_ready bits are 0.
  - winc = req_valid[g] & ~wfull.
  - wdata = req_data[g], muxed combinationally by grant.
- On a beat (winc=1):
  - beat_cnt increments.
  - If beat_cnt reaches MAXBURST-1 before the increment, end the burst.
- End the burst also when req_valid[g]=0 in any BURST cycle.
- On burst end:
  - Go to IDLE, clear grant.
  - rr_ptr <= (g+1) mod NREQ.
- wfull high in BURST: stall. No winc, beat_cnt held, grant held, no timeout.
- A requester holding valid while wfull is high keeps ownership.
- Requesters must hold req_data stable while valid and not ready. The arbiter does not check this.
- winc is never asserted while wfull=1, so the FIFO is never overflowed by this block.
- beat_cnt width: $clog2(MAXBURST)+1. rr_ptr width: $clog2(NREQ).
- Reset (asynchronous, any time including mid-burst):
  - Immediately: state=IDLE, grant=0, busy=0, rr_ptr=0, beat_cnt=0.
  - Combinational outputs follow: req_ready=0, winc=0, wdata=0.
  - A partially written burst is abandoned. The FIFO's own reset handles its contents.

## Timing
- Arbitration latency: one wclk cycle. A valid seen in IDLE at edge n gives grant at n+1, and the first beat can occur in cycle n+1.
- Throughput in BURST: one beat per cycle while wfull=0.
- Idle gap between bursts: exactly one cycle (the IDLE arbitration cycle).
- grant, busy, rr_ptr and the FSM are registered.
- req_ready, winc and wdata are combinational from registered grant/state plus the wfull and req_valid inputs. There is no combinational path from req_valid to grant.
- Simultaneous events:
  - Final beat (count reached) and valid drop in the same cycle: one end-of-burst, rr_ptr advances once.
  - Other requesters raising valid during a burst are ignored until IDLE.

## Structure
- Package fifo_arb_pkg:
  - state_t enum {IDLE, BURST}.
  - Width-helper localparams derived from NREQ and MAXBURST.
- Sub-module rr_pick:
  - Combinational, parameter NREQ.
  - Inputs: req vector, start pointer.
  - Outputs: one-hot pick, its index, any flag.
  - Implemented as a rotate, priority-encode, rotate-back.
- Top holds FSM, counters, data mux.

## Test plan
- Reset/idle: wrst pulse with all valid=0, NREQ=4 -> grant=0, winc=0, req_ready=0, busy=0; outputs stay 0 for 10 cycles.
- Single requester burst: req_valid=4'b0010 continuously, wfull=0, MAXBURST=4 ->
  - grant=0010 one cycle later;
  - exactly 4 winc pulses carrying requester 1's data;
  - one IDLE cycle, then grant=0010 again;
  - rr_ptr=2 after the first burst.
- Round-robin fairness: all four valid continuously, wfull=0 -> grant order 0001, 0010, 0100, 1000, 0001, with 4 beats each and a one-cycle gap between bursts.
- Back-pressure: wfull=1 for cycles 2-5 of a burst ->
  - winc=0 and req_ready=0 throughout;
  - beat_cnt frozen, grant unchanged;
  - the burst completes 4 beats total after wfull drops;
  - no winc with wfull=1, checked by assertion over the whole run.
- Early termination: requester 2 drops valid after 2 beats -> burst ends, FIFO receives exactly 2 beats, rr_ptr=3, next grant goes to the next valid requester at or after index 3.
- Reset mid-burst: assert wrst after beat 2 -> grant=0 and winc=0 within the same cycle; after release, arbitration restarts from rr_ptr=0.
